capi_get_arb: RTL and testbench

//  Shares one capi_get_plus get engine among NREQ client streams. A round-robin arbiter feeds the engine's command port.
//  An in-order owner queue tracks which client issued each outstanding get. Returned data beats are steered back to

---
 rtl/capi_get_arb_ownq.sv | 51 +++++
 rtl/capi_get_arb.sv | 171 +++++++++++++++++
 tb/tb_capi_get_arb.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/capi_get_arb_ownq.sv
// In-order FIFO of client ids, one entry per get issued to the engine and not yet finished.
// The head is the client that owns the data beats currently returning from the engine.
module capi_get_arb_ownq #(
  parameter int ID_W = 2,
  parameter int LG   = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push_i,
  input  logic [ID_W-1:0] push_id_i,
  input  logic            pop_i,
  output logic [ID_W-1:0] head_o,
  output logic [LG:0]     cnt_o,
  output logic            full_o,
  output logic            empty_o
);
  localparam int DEPTH = 1 << LG;

  logic [ID_W-1:0] mem_q [DEPTH];
  logic [LG-1:0]   wr_q, rd_q;
  logic [LG:0]     cnt_q;
  logic            do_push, do_pop;

  assign full_o  = (cnt_q == (LG+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign head_o  = mem_q[rd_q];
  assign cnt_o   = cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage carries no reset; an entry is only read once the count covers it.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= push_id_i;
  end
endmodule

// File: rtl/capi_get_arb.sv
// Round-robin sharing of one get engine among nreq clients: a one-deep command register feeds the engine,
// and an owner queue steers returned beats back to the client that issued each get, in issue order.
module capi_get_arb #(
  parameter int nreq         = 4,
  parameter int ea_width     = 65,
  parameter int ctxtid_width = 9,
  parameter int aux_width    = 1,
  parameter int ssize_width  = 18,
  parameter int rc_width     = 1,
  parameter int oq_lg        = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [nreq-1:0]              i_en,
  input  logic [nreq-1:0]              i_req_v,
  input  logic [nreq*ea_width-1:0]     i_req_addr,
  input  logic [nreq*ctxtid_width-1:0] i_req_ctxt,
  input  logic [nreq*aux_width-1:0]    i_req_aux,
  input  logic [nreq*ssize_width-1:0]  i_req_size,
  output logic [nreq-1:0]              o_req_r,
  output logic                         get_valid,
  output logic [ea_width-1:0]          get_addr,
  output logic [ctxtid_width-1:0]      get_ctxt,
  output logic [aux_width-1:0]         get_aux,
  output logic [ssize_width-1:0]       get_size,
  input  logic                         get_acc,
  input  logic                         get_data_v,
  output logic                         get_data_r,
  input  logic                         get_data_e,
  input  logic [3:0]                   get_data_c,
  input  logic [ssize_width-1:0]       get_data_bcnt,
  input  logic [rc_width-1:0]          get_data_rc,
  input  logic [129:0]                 get_data_d,
  output logic [nreq-1:0]              o_cl_data_v,
  input  logic [nreq-1:0]              i_cl_data_r,
  output logic                         o_cl_data_e,
  output logic [3:0]                   o_cl_data_c,
  output logic [ssize_width-1:0]       o_cl_data_bcnt,
  output logic [rc_width-1:0]          o_cl_data_rc,
  output logic [129:0]                 o_cl_data_d,
  output logic [nreq-1:0]              o_cl_data_own,
  output logic [oq_lg:0]               o_oq_cnt,
  output logic                         o_err
);
  localparam int IDW   = (nreq > 1) ? $clog2(nreq) : 1;
  localparam int DEPTH = 1 << oq_lg;

  logic [nreq-1:0]         elig;
  logic [IDW-1:0]          ptr_q, win_id, cand;
  logic                    any_elig, room, grant;
  logic [oq_lg+1:0]        resv;
  logic                    cmd_v_q;
  logic [IDW-1:0]          cmd_id_q;
  logic [ea_width-1:0]     cmd_addr_q, sel_addr;
  logic [ctxtid_width-1:0] cmd_ctxt_q, sel_ctxt;
  logic [aux_width-1:0]    cmd_aux_q, sel_aux;
  logic [ssize_width-1:0]  cmd_size_q, sel_size;
  logic [IDW-1:0]          head;
  logic                    oq_full, oq_empty;
  logic                    push, pop, xfer;
  logic [nreq-1:0]         own_q;
  logic                    err_q;

  assign elig = i_req_v & i_en;

  // First eligible client at or after the round-robin pointer.
  always_comb begin
    win_id   = '0;
    cand     = '0;
    any_elig = 1'b0;
    for (int k = 0; k < nreq; k++) begin
      cand = IDW'((int'(ptr_q) + k) % nreq);
      if (!any_elig && elig[cand]) begin
        any_elig = 1'b1;
        win_id   = cand;
      end
    end
  end

  always_comb begin
    sel_addr = '0;
    sel_ctxt = '0;
    sel_aux  = '0;
    sel_size = '0;
    for (int c = 0; c < nreq; c++) begin
      if (IDW'(c) == win_id) begin
        sel_addr = i_req_addr[(nreq-1-c)*ea_width +: ea_width];
        sel_ctxt = i_req_ctxt[(nreq-1-c)*ctxtid_width +: ctxtid_width];
        sel_aux  = i_req_aux[(nreq-1-c)*aux_width +: aux_width];
        sel_size = i_req_size[(nreq-1-c)*ssize_width +: ssize_width];
      end
    end
  end

  // A command sitting in the register already holds a queue slot.
  assign resv    = {1'b0, o_oq_cnt} + (oq_lg+2)'(cmd_v_q);
  assign room    = (resv < (oq_lg+2)'(DEPTH));
  assign grant   = any_elig & room & (~cmd_v_q | get_acc) & ~reset;
  assign o_req_r = grant ? (nreq'(1) << win_id) : '0;

  assign push = cmd_v_q & get_acc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q    <= '0;
      cmd_v_q  <= 1'b0;
      cmd_id_q <= '0;
    end else begin
      if (grant) begin
        ptr_q    <= IDW'((int'(win_id) + 1) % nreq);
        cmd_v_q  <= 1'b1;
        cmd_id_q <= win_id;
      end else if (get_acc) begin
        cmd_v_q  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (grant) begin
      cmd_addr_q <= sel_addr;
      cmd_ctxt_q <= sel_ctxt;
      cmd_aux_q  <= sel_aux;
      cmd_size_q <= sel_size;
    end
  end

  assign get_valid = cmd_v_q;
  assign get_addr  = cmd_addr_q;
  assign get_ctxt  = cmd_ctxt_q;
  assign get_aux   = cmd_aux_q;
  assign get_size  = cmd_size_q;

  capi_get_arb_ownq #(.ID_W(IDW), .LG(oq_lg)) u_ownq (
    .clk       (clk),
    .reset     (reset),
    .push_i    (push),
    .push_id_i (cmd_id_q),
    .pop_i     (pop),
    .head_o    (head),
    .cnt_o     (o_oq_cnt),
    .full_o    (oq_full),
    .empty_o   (oq_empty)
  );

  // Return path: beats go to the queue head until its end beat is taken.
  assign o_cl_data_v = (get_data_v & ~oq_empty) ? (nreq'(1) << head) : '0;
  assign get_data_r  = ~oq_empty & i_cl_data_r[head];
  assign xfer        = get_data_v & get_data_r;
  assign pop         = xfer & get_data_e;

  assign o_cl_data_e    = get_data_e;
  assign o_cl_data_c    = get_data_c;
  assign o_cl_data_bcnt = get_data_bcnt;
  assign o_cl_data_rc   = get_data_rc;
  assign o_cl_data_d    = get_data_d;

  // Owner is registered so it lines up with data arriving a cycle after its valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      own_q <= '0;
      err_q <= 1'b0;
    end else begin
      own_q <= xfer ? (nreq'(1) << head) : '0;
      err_q <= err_q | (get_data_v & oq_empty);
    end
  end

  assign o_cl_data_own = own_q;
  assign o_err         = err_q;
endmodule

// File: tb/tb_capi_get_arb.sv
// Directed bench for capi_get_arb: arbitration order, queue-full backpressure, owner steering and error/reset.
module tb_capi_get_arb;
  localparam int NREQ = 4, EAW = 65, CXW = 9, AXW = 1, SSW = 18, RCW = 1, OQL = 2;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NREQ-1:0]      i_en, i_req_v, o_req_r;
  logic [NREQ*EAW-1:0]  i_req_addr;
  logic [NREQ*CXW-1:0]  i_req_ctxt;
  logic [NREQ*AXW-1:0]  i_req_aux;
  logic [NREQ*SSW-1:0]  i_req_size;
  logic                 get_valid, get_acc, get_data_v, get_data_r, get_data_e;
  logic [EAW-1:0]       get_addr;
  logic [CXW-1:0]       get_ctxt;
  logic [AXW-1:0]       get_aux;
  logic [SSW-1:0]       get_size, get_data_bcnt, o_cl_data_bcnt;
  logic [3:0]           get_data_c, o_cl_data_c;
  logic [RCW-1:0]       get_data_rc, o_cl_data_rc;
  logic [129:0]         get_data_d, o_cl_data_d;
  logic [NREQ-1:0]      o_cl_data_v, i_cl_data_r, o_cl_data_own;
  logic                 o_cl_data_e, o_err;
  logic [OQL:0]         o_oq_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  capi_get_arb #(.nreq(NREQ), .ea_width(EAW), .ctxtid_width(CXW), .aux_width(AXW),
                 .ssize_width(SSW), .rc_width(RCW), .oq_lg(OQL)) dut (
    .clk(clk), .reset(reset), .i_en(i_en), .i_req_v(i_req_v), .i_req_addr(i_req_addr),
    .i_req_ctxt(i_req_ctxt), .i_req_aux(i_req_aux), .i_req_size(i_req_size), .o_req_r(o_req_r),
    .get_valid(get_valid), .get_addr(get_addr), .get_ctxt(get_ctxt), .get_aux(get_aux),
    .get_size(get_size), .get_acc(get_acc), .get_data_v(get_data_v), .get_data_r(get_data_r),
    .get_data_e(get_data_e), .get_data_c(get_data_c), .get_data_bcnt(get_data_bcnt),
    .get_data_rc(get_data_rc), .get_data_d(get_data_d), .o_cl_data_v(o_cl_data_v),
    .i_cl_data_r(i_cl_data_r), .o_cl_data_e(o_cl_data_e), .o_cl_data_c(o_cl_data_c),
    .o_cl_data_bcnt(o_cl_data_bcnt), .o_cl_data_rc(o_cl_data_rc), .o_cl_data_d(o_cl_data_d),
    .o_cl_data_own(o_cl_data_own), .o_oq_cnt(o_oq_cnt), .o_err(o_err)
  );

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_client(input int c, input logic [EAW-1:0] a, input logic [CXW-1:0] x,
                            input logic [AXW-1:0] u, input logic [SSW-1:0] s);
    i_req_addr[(NREQ-1-c)*EAW +: EAW] = a;
    i_req_ctxt[(NREQ-1-c)*CXW +: CXW] = x;
    i_req_aux[(NREQ-1-c)*AXW +: AXW]  = u;
    i_req_size[(NREQ-1-c)*SSW +: SSW] = s;
  endtask

  task automatic idle_inputs();
    i_en = 4'hf; i_req_v = '0; get_acc = 1'b0; get_data_v = 1'b0; get_data_e = 1'b0;
    get_data_c = '0; get_data_bcnt = '0; get_data_rc = '0; get_data_d = '0; i_cl_data_r = '0;
    set_client(0, 65'h0_0000_0000_0000_a000, 9'h011, 1'b0, 18'h00100);
    set_client(1, 65'h0_0000_0000_0000_b000, 9'h022, 1'b1, 18'h00200);
    set_client(2, 65'h1_dead_beef_0000_1000, 9'h1a5, 1'b1, 18'h00400);
    set_client(3, 65'h0_cafe_f00d_0000_3000, 9'h0f3, 1'b0, 18'h00800);
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    i_req_v = 4'b0101;
    get_data_v = 1'b1;
    i_cl_data_r = 4'hf;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (get_valid !== 1'b0) begin errors++; $display("FAIL rst_get_valid got %b exp 0", get_valid); end
    checks++; if (o_req_r !== 4'b0000) begin errors++; $display("FAIL rst_req_r got %b exp 0000", o_req_r); end
    checks++; if (get_data_r !== 1'b0) begin errors++; $display("FAIL rst_data_r got %b exp 0", get_data_r); end
    checks++; if (o_cl_data_v !== 4'b0000) begin errors++; $display("FAIL rst_cl_v got %b exp 0000", o_cl_data_v); end
    checks++; if (o_cl_data_own !== 4'b0000) begin errors++; $display("FAIL rst_own got %b exp 0000", o_cl_data_own); end
    checks++; if (o_oq_cnt !== 3'd0) begin errors++; $display("FAIL rst_cnt got %0d exp 0", o_oq_cnt); end
    checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL rst_err got %b exp 0", o_err); end
    idle_inputs();
    reset = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    i_req_v = 4'b0100; #1;
    checks++; if (o_req_r !== 4'b0100) begin errors++; $display("FAIL t1_grant got %b exp 0100", o_req_r); end
    tick(); i_req_v = '0; #1;
    checks++; if (get_valid !== 1'b1) begin errors++; $display("FAIL t1_valid got %b exp 1", get_valid); end
    checks++; if (get_addr !== 65'h1_dead_beef_0000_1000) begin errors++; $display("FAIL t1_addr got %h exp 1deadbeef00001000", get_addr); end
    checks++; if (get_ctxt !== 9'h1a5) begin errors++; $display("FAIL t1_ctxt got %h exp 1a5", get_ctxt); end
    checks++; if (get_aux !== 1'b1) begin errors++; $display("FAIL t1_aux got %b exp 1", get_aux); end
    checks++; if (get_size !== 18'h00400) begin errors++; $display("FAIL t1_size got %h exp 00400", get_size); end
    tick();
    checks++; if (get_valid !== 1'b1) begin errors++; $display("FAIL t1_hold got %b exp 1", get_valid); end
    get_acc = 1'b1; tick(); get_acc = 1'b0; #1;
    checks++; if (get_valid !== 1'b0) begin errors++; $display("FAIL t1_acc_drop got %b exp 0", get_valid); end
    checks++; if (o_oq_cnt !== 3'd1) begin errors++; $display("FAIL t1_cnt1 got %0d exp 1", o_oq_cnt); end
    get_data_v = 1'b1; i_cl_data_r = 4'b0100; #1;
    checks++; if (o_cl_data_v !== 4'b0100) begin errors++; $display("FAIL t1_cl_v got %b exp 0100", o_cl_data_v); end
    checks++; if (get_data_r !== 1'b1) begin errors++; $display("FAIL t1_data_r got %b exp 1", get_data_r); end
    tick(); get_data_d = {2'b10, 128'h0123_4567_89ab_cdef_0011_2233_4455_6677};
    get_data_e = 1'b1; get_data_c = 4'h3; #1;
    checks++; if (o_cl_data_own !== 4'b0100) begin errors++; $display("FAIL t1_own got %b exp 0100", o_cl_data_own); end
    checks++; if (o_cl_data_d !== {2'b10, 128'h0123_4567_89ab_cdef_0011_2233_4455_6677}) begin errors++; $display("FAIL t1_d got %h", o_cl_data_d); end
    checks++; if (o_cl_data_e !== 1'b1 || o_cl_data_c !== 4'h3) begin errors++; $display("FAIL t1_ec got %b/%h exp 1/3", o_cl_data_e, o_cl_data_c); end
    tick(); get_data_v = 1'b0; get_data_e = 1'b0; #1;
    checks++; if (o_oq_cnt !== 3'd0) begin errors++; $display("FAIL t1_cnt0 got %0d exp 0", o_oq_cnt); end
    checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL t1_err got %b exp 0", o_err); end
  endtask

  task automatic test_rr_order();
    logic [NREQ-1:0] exp_r;
    do_reset();
    i_req_v = 4'hf; get_acc = 1'b1; i_cl_data_r = 4'hf; get_data_e = 1'b1;
    for (int g = 0; g < 5; g++) begin
      get_data_v = (g >= 2); #1;
      exp_r = 4'b0001 << (g % 4);
      checks++; if (o_req_r !== exp_r) begin errors++; $display("FAIL t2_grant%0d got %b exp %b", g, o_req_r, exp_r); end
      tick();
    end
    i_req_v = '0; get_data_v = 1'b1; #1;
    checks++; if (o_req_r !== 4'b0000) begin errors++; $display("FAIL t2_nogrant got %b exp 0000", o_req_r); end
    checks++; if (o_cl_data_v !== 4'b1000) begin errors++; $display("FAIL t2_head3 got %b exp 1000", o_cl_data_v); end
    tick(); #1;
    checks++; if (o_cl_data_v !== 4'b0001) begin errors++; $display("FAIL t2_head0 got %b exp 0001", o_cl_data_v); end
    tick(); get_data_v = 1'b0; get_acc = 1'b0; #1;
    checks++; if (o_oq_cnt !== 3'd0) begin errors++; $display("FAIL t2_cnt got %0d exp 0", o_oq_cnt); end
    checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL t2_err got %b exp 0", o_err); end
  endtask

  task automatic test_queue_full();
    do_reset();
    i_req_v = 4'b0001; get_acc = 1'b1;
    for (int g = 0; g < 4; g++) begin
      #1;
      checks++; if (o_req_r !== 4'b0001) begin errors++; $display("FAIL t3_grant%0d got %b exp 0001", g, o_req_r); end
      tick();
    end
    checks++; if (o_req_r !== 4'b0000) begin errors++; $display("FAIL t3_block1 got %b exp 0000", o_req_r); end
    tick();
    checks++; if (o_oq_cnt !== 3'd4) begin errors++; $display("FAIL t3_cnt4 got %0d exp 4", o_oq_cnt); end
    checks++; if (o_req_r !== 4'b0000) begin errors++; $display("FAIL t3_block2 got %b exp 0000", o_req_r); end
    get_data_v = 1'b1; get_data_e = 1'b1; i_cl_data_r = 4'b0001; #1;
    checks++; if (get_data_r !== 1'b1) begin errors++; $display("FAIL t3_pop_r got %b exp 1", get_data_r); end
    tick(); get_data_v = 1'b0; get_data_e = 1'b0; #1;
    checks++; if (o_oq_cnt !== 3'd3) begin errors++; $display("FAIL t3_cnt3 got %0d exp 3", o_oq_cnt); end
    checks++; if (o_req_r !== 4'b0001) begin errors++; $display("FAIL t3_regrant got %b exp 0001", o_req_r); end
    i_req_v = '0; get_acc = 1'b0;
  endtask

  task automatic test_owner_order();
    do_reset();
    i_req_v = 4'b0010; get_acc = 1'b1; #1;
    checks++; if (o_req_r !== 4'b0010) begin errors++; $display("FAIL t4_g1 got %b exp 0010", o_req_r); end
    tick(); i_req_v = 4'b1000; #1;
    checks++; if (o_req_r !== 4'b1000) begin errors++; $display("FAIL t4_g3 got %b exp 1000", o_req_r); end
    tick(); i_req_v = '0; #1;
    checks++; if (get_addr !== 65'h0_cafe_f00d_0000_3000) begin errors++; $display("FAIL t4_addr got %h exp 0cafef00d00003000", get_addr); end
    tick(); get_acc = 1'b0; #1;
    checks++; if (o_oq_cnt !== 3'd2) begin errors++; $display("FAIL t4_cnt2 got %0d exp 2", o_oq_cnt); end
    i_cl_data_r = 4'b0010; get_data_v = 1'b1; #1;
    checks++; if (o_cl_data_v !== 4'b0010 || get_data_r !== 1'b1) begin errors++; $display("FAIL t4_c1_v got %b/%b exp 0010/1", o_cl_data_v, get_data_r); end
    tick(); get_data_d = {2'b01, 128'haaaa_0000_0000_0000_0000_0000_0000_0001}; get_data_e = 1'b1; #1;
    checks++; if (o_cl_data_own !== 4'b0010) begin errors++; $display("FAIL t4_own1 got %b exp 0010", o_cl_data_own); end
    tick(); get_data_d = {2'b00, 128'hbbbb_0000_0000_0000_0000_0000_0000_0002}; get_data_e = 1'b0; #1;
    checks++; if (o_cl_data_v !== 4'b1000 || get_data_r !== 1'b0) begin errors++; $display("FAIL t4_c3_stall got %b/%b exp 1000/0", o_cl_data_v, get_data_r); end
    tick();
    checks++; if (get_data_r !== 1'b0 || o_cl_data_own !== 4'b0000) begin errors++; $display("FAIL t4_still got %b/%b exp 0/0000", get_data_r, o_cl_data_own); end
    checks++; if (o_oq_cnt !== 3'd1) begin errors++; $display("FAIL t4_cnt1 got %0d exp 1", o_oq_cnt); end
    i_cl_data_r = 4'b1000; #1;
    checks++; if (get_data_r !== 1'b1) begin errors++; $display("FAIL t4_c3_go got %b exp 1", get_data_r); end
    tick(); get_data_d = {2'b11, 128'hcccc_0000_0000_0000_0000_0000_0000_0003}; get_data_e = 1'b1; #1;
    checks++; if (o_cl_data_own !== 4'b1000) begin errors++; $display("FAIL t4_own3 got %b exp 1000", o_cl_data_own); end
    checks++; if (o_cl_data_d !== {2'b11, 128'hcccc_0000_0000_0000_0000_0000_0000_0003}) begin errors++; $display("FAIL t4_d got %h", o_cl_data_d); end
    tick(); get_data_v = 1'b0; get_data_e = 1'b0; #1;
    checks++; if (o_oq_cnt !== 3'd0) begin errors++; $display("FAIL t4_cnt0 got %0d exp 0", o_oq_cnt); end
  endtask

  task automatic test_empty_err();
    do_reset();
    get_data_v = 1'b1; i_cl_data_r = 4'hf; #1;
    checks++; if (get_data_r !== 1'b0) begin errors++; $display("FAIL t5_r got %b exp 0", get_data_r); end
    checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL t5_err_early got %b exp 0", o_err); end
    tick(); get_data_v = 1'b0; #1;
    checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL t5_err_set got %b exp 1", o_err); end
    tick(); tick();
    checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL t5_err_held got %b exp 1", o_err); end
    reset = 1'b1; #1;
    checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL t5_err_clr got %b exp 0", o_err); end
    tick(); reset = 1'b0;
  endtask

  task automatic test_mid_reset();
    do_reset();
    i_req_v = 4'b0001; get_acc = 1'b1;
    tick(); i_req_v = '0;
    tick(); get_acc = 1'b0; get_data_v = 1'b1; i_cl_data_r = 4'hf; #1;
    checks++; if (o_cl_data_v !== 4'b0001) begin errors++; $display("FAIL t6_stream got %b exp 0001", o_cl_data_v); end
    tick(); i_req_v = 4'b0011; reset = 1'b1; #1;
    checks++; if (o_cl_data_v !== 4'b0000 || get_data_r !== 1'b0) begin errors++; $display("FAIL t6_rst_data got %b/%b exp 0000/0", o_cl_data_v, get_data_r); end
    checks++; if (o_oq_cnt !== 3'd0 || get_valid !== 1'b0) begin errors++; $display("FAIL t6_rst_q got %0d/%b exp 0/0", o_oq_cnt, get_valid); end
    checks++; if (o_req_r !== 4'b0000 || o_cl_data_own !== 4'b0000) begin errors++; $display("FAIL t6_rst_req got %b/%b exp 0000/0000", o_req_r, o_cl_data_own); end
    tick(); get_data_v = 1'b0; reset = 1'b0; #1;
    checks++; if (o_req_r !== 4'b0001) begin errors++; $display("FAIL t6_ptr got %b exp 0001", o_req_r); end
    tick(); i_req_v = '0; #1;
    checks++; if (get_valid !== 1'b1 || get_addr !== 65'h0_0000_0000_0000_a000) begin errors++; $display("FAIL t6_cmd got %b/%h exp 1/a000", get_valid, get_addr); end
    checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL t6_err got %b exp 0", o_err); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout got running exp finished");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single();
    test_rr_order();
    test_queue_full();
    test_owner_order();
    test_empty_err();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
